imem_loader: RTL and testbench

Byte-stream program loader that sits directly upstream of the instruction memory write port. It accepts a framed program image from a byte source (UART receiver), assembles little-endian 32-bit words and writes them to consecutive instruction-memory addresses. It holds the pipeline in reset until a complete, checksum-verified image has been written.

---
 rtl/imem_loader.sv | 191 +++++++++++++++++++
 tb/tb_imem_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: assembles little-endian words from LEN_LO, LEN_HI,
// 4*N data bytes and CSUM, writes them to instruction memory, and releases cpu_hold on success.
module imem_loader #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [9:0]  imem_addr_w,
  output logic [31:0] imem_din,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [10:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  w_code;

  logic [7:0]  r_sum;
  logic [1:0]  r_lane;
  logic [7:0]  r_len_lo;
  logic [10:0] r_len;
  logic [10:0] r_wcnt;
  logic [23:0] r_word;
  logic [31:0] r_idle;

  logic        r_rx_ready;
  logic        r_we;
  logic [9:0]  r_addr;
  logic [31:0] r_din;
  logic        r_hold;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [1:0]  r_code;
  logic [10:0] r_words;

  logic        w_acc;
  logic [10:0] w_len;
  logic        w_len_ok;
  logic        w_last_data;
  logic [31:0] w_idle_next;
  logic        w_timeout;
  logic        w_start_ok;
  logic        w_next_busy;

  assign w_acc       = rx_valid && r_rx_ready;
  assign w_len       = {rx_data[2:0], r_len_lo};
  assign w_len_ok    = (rx_data[7:3] == 5'd0) && (w_len != 11'd0) && (w_len <= 11'd1024);
  assign w_last_data = (r_lane == 2'd3) && ((r_wcnt + 11'd1) == r_len);
  assign w_idle_next = r_idle + 32'd1;
  assign w_timeout   = (TIMEOUT != 0) && r_busy && !w_acc && (w_idle_next == TIMEOUT);
  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  assign w_next_busy = (w_next == S_HDR0) || (w_next == S_HDR1) ||
                       (w_next == S_DATA) || (w_next == S_CSUM);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_code = r_code;
    if (w_start_ok) begin
      w_next = S_HDR0;
      w_code = 2'b00;
    end else if (w_timeout) begin
      w_next = S_ERR;
      w_code = 2'b11;
    end else if (w_acc) begin
      case (r_state)
        S_HDR0: w_next = S_HDR1;
        S_HDR1: begin
          if (w_len_ok) begin
            w_next = S_DATA;
          end else begin
            w_next = S_ERR;
            w_code = 2'b01;
          end
        end
        S_DATA: if (w_last_data) w_next = S_CSUM;
        S_CSUM: begin
          if (rx_data == r_sum) begin
            w_next = S_DONE;
          end else begin
            w_next = S_ERR;
            w_code = 2'b10;
          end
        end
        default: w_next = r_state;
      endcase
    end
  end

  // Outputs are registered from the next state so they change together with r_state.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rx_ready <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 10'd0;
      r_din      <= 32'd0;
      r_hold     <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_code     <= 2'b00;
      r_words    <= 11'd0;
      r_sum      <= 8'd0;
      r_lane     <= 2'd0;
      r_wcnt     <= 11'd0;
      r_idle     <= 32'd0;
    end else begin
      r_rx_ready <= w_next_busy;
      r_busy     <= w_next_busy;
      r_hold     <= (w_next != S_DONE);
      r_done     <= (w_next == S_DONE);
      r_err      <= (w_next == S_ERR);
      r_code     <= w_code;
      r_we       <= 1'b0;

      if (r_we) begin
        r_addr  <= r_addr + 10'd1;
        r_words <= r_words + 11'd1;
      end

      if (w_start_ok) begin
        r_sum   <= 8'd0;
        r_lane  <= 2'd0;
        r_wcnt  <= 11'd0;
        r_idle  <= 32'd0;
        r_addr  <= 10'd0;
        r_words <= 11'd0;
      end else if (r_busy) begin
        r_idle <= w_acc ? 32'd0 : w_idle_next;
      end

      if (w_acc) begin
        case (r_state)
          S_HDR0: begin
            r_sum    <= r_sum + rx_data;
            r_len_lo <= rx_data;
          end
          S_HDR1: begin
            r_sum <= r_sum + rx_data;
            r_len <= w_len;
          end
          S_DATA: begin
            r_sum  <= r_sum + rx_data;
            r_lane <= r_lane + 2'd1;
            case (r_lane)
              2'd0: r_word[7:0]   <= rx_data;
              2'd1: r_word[15:8]  <= rx_data;
              2'd2: r_word[23:16] <= rx_data;
              default: begin
                r_we   <= 1'b1;
                r_din  <= {rx_data, r_word};
                r_wcnt <= r_wcnt + 11'd1;
              end
            endcase
          end
          default: r_sum <= r_sum;
        endcase
      end
    end
  end

  assign rx_ready     = r_rx_ready;
  assign imem_we      = r_we;
  assign imem_addr_w  = r_addr;
  assign imem_din     = r_din;
  assign cpu_hold     = r_hold;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;
  assign err_code     = r_code;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad frames, length errors, full 1024-word image,
// idle timeout and mid-load reset, with writes captured by a negedge monitor.
module tb_imem_loader;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [9:0]  imem_addr_w;
  logic [31:0] imem_din;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [10:0] words_loaded;

  always #5 sys_clk = ~sys_clk;

  imem_loader #(.TIMEOUT(16)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr_w  (imem_addr_w),
    .imem_din     (imem_din),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_code     (err_code),
    .words_loaded (words_loaded)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [9:0]  wr_addr [0:4095];
  logic [31:0] wr_data [0:4095];
  int          wr_cnt = 0;
  int          multi_we = 0;
  logic        prev_we = 1'b0;
  logic [31:0] exp_w [0:1023];

  always @(negedge sys_clk) begin
    if (imem_we === 1'b1) begin
      if (wr_cnt < 4096) begin
        wr_addr[wr_cnt] = imem_addr_w;
        wr_data[wr_cnt] = imem_din;
      end
      wr_cnt++;
      if (prev_we === 1'b1) multi_we++;
    end
    prev_we = imem_we;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && t < 40) begin
      @(negedge sys_clk);
      t++;
    end
    if (t >= 40) begin
      chk("rx_ready_wait", 32'(rx_ready), 32'd1);
      rx_valid = 1'b0;
    end else begin
      @(negedge sys_clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic gap();
    int n;
    n = int'($urandom_range(0, 2));
    rx_valid = 1'b0;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_n2_frame(input logic [7:0] csum);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    send_byte(8'hDD); send_byte(8'hCC); send_byte(8'hBB); send_byte(8'hAA);
    send_byte(csum);
    rx_valid = 1'b0;
  endtask

  initial begin
    int base;
    logic [7:0] sum;
    logic [7:0] b;
    sys_rst  = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge sys_clk);

    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr_w), 32'd0);
    chk("rst_din", imem_din, 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // N=2 good frame, back-to-back
    base = wr_cnt;
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready", 32'(rx_ready), 32'd1);
    send_n2_frame(8'hBA);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_hold", 32'(cpu_hold), 32'd0);
    chk("t1_words", 32'(words_loaded), 32'd2);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_ready_end", 32'(rx_ready), 32'd0);
    chk("t1_nwr", 32'(wr_cnt - base), 32'd2);
    chk("t1_a0", 32'(wr_addr[base]), 32'd0);
    chk("t1_d0", wr_data[base], 32'h11223344);
    chk("t1_a1", 32'(wr_addr[base+1]), 32'd1);
    chk("t1_d1", wr_data[base+1], 32'hAABBCCDD);
    chk("t1_din_hold", imem_din, 32'hAABBCCDD);
    chk("t1_we_idle", 32'(imem_we), 32'd0);

    // Bad checksum, then recovery
    pulse_start();
    chk("t2_words_clr", 32'(words_loaded), 32'd0);
    chk("t2_addr_clr", 32'(imem_addr_w), 32'd0);
    chk("t2_done_clr", 32'(done), 32'd0);
    chk("t2_hold_set", 32'(cpu_hold), 32'd1);
    send_n2_frame(8'hBB);
    chk("t2_err", 32'(err), 32'd1);
    chk("t2_code", 32'(err_code), 32'd2);
    chk("t2_hold", 32'(cpu_hold), 32'd1);
    chk("t2_done", 32'(done), 32'd0);
    base = wr_cnt;
    pulse_start();
    chk("t2_err_clr", 32'(err), 32'd0);
    chk("t2_code_clr", 32'(err_code), 32'd0);
    send_n2_frame(8'hBA);
    chk("t2_done2", 32'(done), 32'd1);
    chk("t2_words2", 32'(words_loaded), 32'd2);
    chk("t2_a0", 32'(wr_addr[base]), 32'd0);
    chk("t2_d0", wr_data[base], 32'h11223344);

    // Length errors: N=1025 and N=0
    base = wr_cnt;
    pulse_start();
    send_byte(8'h01); send_byte(8'h04);
    rx_valid = 1'b0;
    chk("t3_err_1025", 32'(err), 32'd1);
    chk("t3_code_1025", 32'(err_code), 32'd1);
    chk("t3_ready_1025", 32'(rx_ready), 32'd0);
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    rx_valid = 1'b0;
    chk("t3_err_0", 32'(err), 32'd1);
    chk("t3_code_0", 32'(err_code), 32'd1);
    repeat (3) @(negedge sys_clk);
    chk("t3_no_we", 32'(wr_cnt - base), 32'd0);

    // N=1024 random data with random rx_valid gaps
    base = wr_cnt;
    pulse_start();
    sum = 8'h04;
    send_byte(8'h00); gap();
    send_byte(8'h04); gap();
    for (int w = 0; w < 1024; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'($urandom);
        exp_w[w][8*k +: 8] = b;
        sum = sum + b;
        send_byte(b);
        gap();
      end
    end
    send_byte(sum);
    rx_valid = 1'b0;
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_hold", 32'(cpu_hold), 32'd0);
    chk("t4_words", 32'(words_loaded), 32'd1024);
    chk("t4_nwr", 32'(wr_cnt - base), 32'd1024);
    for (int w = 0; w < 1024; w++) begin
      chk("t4_addr", 32'(wr_addr[base+w]), 32'(w));
      chk("t4_data", wr_data[base+w], exp_w[w]);
    end

    // Timeout after 5 data bytes
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
    rx_valid = 1'b0;
    repeat (15) @(negedge sys_clk);
    chk("t5_err_early", 32'(err), 32'd0);
    chk("t5_busy_early", 32'(busy), 32'd1);
    @(negedge sys_clk);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_code", 32'(err_code), 32'd3);
    chk("t5_ready", 32'(rx_ready), 32'd0);
    chk("t5_hold", 32'(cpu_hold), 32'd1);

    // Reset mid-DATA on the cycle the 4th byte of a word is offered
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22);
    base = wr_cnt;
    rx_data  = 8'h11;
    rx_valid = 1'b1;
    sys_rst  = 1'b1;
    @(negedge sys_clk);
    sys_rst  = 1'b0;
    rx_valid = 1'b0;
    chk("t6_rst_ready", 32'(rx_ready), 32'd0);
    chk("t6_rst_we", 32'(imem_we), 32'd0);
    chk("t6_rst_addr", 32'(imem_addr_w), 32'd0);
    chk("t6_rst_din", imem_din, 32'd0);
    chk("t6_rst_hold", 32'(cpu_hold), 32'd1);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_words", 32'(words_loaded), 32'd0);
    chk("t6_rst_code", 32'(err_code), 32'd0);
    repeat (3) @(negedge sys_clk);
    chk("t6_no_we", 32'(wr_cnt - base), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    pulse_start();
    send_byte(8'h01);
    rx_valid = 1'b0;
    pulse_start();
    chk("t6_hdr1_busy", 32'(busy), 32'd1);
    chk("t6_hdr1_err", 32'(err), 32'd0);
    send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h15);
    rx_valid = 1'b0;
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_words", 32'(words_loaded), 32'd1);
    chk("t6_nwr", 32'(wr_cnt - base), 32'd1);
    chk("t6_a0", 32'(wr_addr[base]), 32'd0);
    chk("t6_d0", wr_data[base], 32'h12345678);

    chk("we_single_cycle", 32'(multi_we), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
